// File: rtl/p_s.sv
// Parallel-to-serial converter: splits a NUM_WORDS*WORD_W frame into NUM_WORDS words, MSB word first.
// One-edge latency from load to word 0; loads are refused (busy) until the frame's last word is on the output.
module p_s #(
  parameter int WORD_W    = 34,
  parameter int NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_W*NUM_WORDS-1:0]   data_in_3,
  input  logic                          p_s_flag_in,
  output logic [WORD_W-1:0]             data_out_3,
  output logic                          p_s_flag_out,
  output logic                          busy
);

  localparam int FRAME_W = WORD_W * NUM_WORDS;
  localparam int CNT_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   frame;
  logic                 load;
  logic [FRAME_W-1:0]   frame_shifted;
  logic [WORD_W-1:0]    next_word;

  // A new frame may be accepted while idle or in the same edge the last word leaves.
  assign load          = p_s_flag_in && ((state == IDLE) || (cnt == LAST));
  assign frame_shifted = frame << (WORD_W * (int'(cnt) + 1));
  assign next_word     = frame_shifted[FRAME_W-1 -: WORD_W];
  assign busy          = (state == SHIFT) && (cnt != LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      frame        <= '0;
      data_out_3   <= '0;
      p_s_flag_out <= 1'b0;
    end else if (load) begin
      frame        <= data_in_3;
      data_out_3   <= data_in_3[FRAME_W-1 -: WORD_W];
      p_s_flag_out <= 1'b1;
      cnt          <= '0;
      state        <= SHIFT;
    end else if ((state == SHIFT) && (cnt != LAST)) begin
      cnt          <= cnt + 1'b1;
      data_out_3   <= next_word;
      p_s_flag_out <= 1'b1;
    end else begin
      state        <= IDLE;
      cnt          <= '0;
      data_out_3   <= '0;
      p_s_flag_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p_s.sv
// Bench for p_s: reference model keeps a queue of words still to be emitted; expected outputs are
// queued when inputs are driven and compared one edge later.
module tb_p_s;

  localparam int W  = 34;
  localparam int N  = 4;
  localparam int FW = W * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] data_in_3;
  logic          p_s_flag_in;
  logic [W-1:0]  data_out_3;
  logic          p_s_flag_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rem[$];
  logic [W-1:0] sb_dat[$];
  logic         sb_vld[$];

  p_s #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_3    (data_in_3),
    .p_s_flag_in  (p_s_flag_in),
    .data_out_3   (data_out_3),
    .p_s_flag_out (p_s_flag_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input logic [FW-1:0] f, input int k);
    logic [FW-1:0] t;
    t = f >> (W * (N - 1 - k));
    return t[W-1:0];
  endfunction

  // Inputs already set for the coming edge: predict, clock, compare.
  task automatic edge_and_check(output logic loaded);
    logic [W-1:0] ed;
    logic         ev;
    chk("busy", busy, rem.size() > 0);
    loaded = 1'b0;
    if (p_s_flag_in && rem.size() == 0) begin
      loaded = 1'b1;
      ed = word_of(data_in_3, 0);
      ev = 1'b1;
      for (int k = 1; k < N; k++) rem.push_back(word_of(data_in_3, k));
    end else if (rem.size() > 0) begin
      ed = rem.pop_front();
      ev = 1'b1;
    end else begin
      ed = '0;
      ev = 1'b0;
    end
    sb_dat.push_back(ed);
    sb_vld.push_back(ev);
    @(posedge clk);
    #1;
    if (sb_dat.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      chk("data_out_3", data_out_3, sb_dat.pop_front());
      chk("p_s_flag_out", p_s_flag_out, sb_vld.pop_front());
    end
  endtask

  task automatic step(input logic f, input logic [FW-1:0] d);
    logic ld;
    @(negedge clk);
    p_s_flag_in = f;
    data_in_3   = d;
    edge_and_check(ld);
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_dat"}, data_out_3, 0);
    chk({tag, "_vld"}, p_s_flag_out, 0);
    chk({tag, "_busy"}, busy, 0);
    rem.delete();
  endtask

  // Release at a falling edge so the very next rising edge is a normal one.
  task automatic release_with(input logic f, input logic [FW-1:0] d);
    logic ld;
    @(negedge clk);
    rst_n       = 1'b1;
    p_s_flag_in = f;
    data_in_3   = d;
    edge_and_check(ld);
  endtask

  logic [FW-1:0] fa, fb, fones, fr;
  logic          ld;
  int            loaded_cnt;
  int            cyc;

  initial begin
    rst_n       = 1'b0;
    p_s_flag_in = 1'b0;
    data_in_3   = '0;
    #2;
    chk("rst_dat", data_out_3, 0);
    chk("rst_vld", p_s_flag_out, 0);
    chk("rst_busy", busy, 0);
    release_with(1'b0, '0);
    step(1'b0, '0);

    // Single frame 1,2,3,4
    fa = {34'h1, 34'h2, 34'h3, 34'h4};
    step(1'b1, fa);
    chk("sf_w0", data_out_3, 1);
    for (int k = 1; k < N; k++) begin
      step(1'b0, '0);
      chk("sf_wk", data_out_3, k + 1);
    end
    step(1'b0, '0);
    step(1'b0, '0);

    // Load request while cnt=1 must be ignored
    fa = {34'h5, 34'h6, 34'h7, 34'h8};
    fb = {34'h3AAAAAAAA, 34'h155555555, 34'h0DEADBEEF, 34'h2CAFEF00D};
    step(1'b1, fa);
    step(1'b0, fb);
    @(negedge clk);
    p_s_flag_in = 1'b1;
    data_in_3   = fb;
    chk("ign_busy", busy, 1);
    edge_and_check(ld);
    chk("ign_w2", data_out_3, 34'h7);
    step(1'b0, fb);
    chk("ign_w3", data_out_3, 34'h8);
    step(1'b0, '0);

    // Back-to-back frames A then B with the request held high
    for (int k = 0; k < N; k++) step(1'b1, fa);
    for (int k = 0; k < N; k++) step(1'b1, fb);
    chk("b2b_last", data_out_3, 34'h2CAFEF00D);
    step(1'b0, '0);
    step(1'b0, '0);

    // Mid-frame reset after word 1
    fones = {N{34'h3FFFFFFFF}};
    step(1'b1, fones);
    step(1'b0, '0);
    chk("mr_w1", data_out_3, 34'h3FFFFFFFF);
    async_reset_check("mr");
    @(posedge clk);
    #1;
    chk("mr_hold_dat", data_out_3, 0);
    release_with(1'b0, '0);
    for (int k = 0; k < N; k++) step(1'b0, fones);

    // Reset again, then a load on the first edge after release is honoured
    step(1'b1, fa);
    async_reset_check("r2");
    release_with(1'b1, fb);
    chk("rel_load", data_out_3, 34'h3AAAAAAAA);
    for (int k = 0; k < N; k++) step(1'b0, '0);

    // Random frames and request pattern
    loaded_cnt = 0;
    cyc        = 0;
    while (loaded_cnt < 16 && cyc < 400) begin
      fr = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      p_s_flag_in = ($urandom_range(0, 3) != 0);
      data_in_3   = fr;
      edge_and_check(ld);
      if (ld) loaded_cnt++;
      cyc++;
    end
    chk("rand_loads", loaded_cnt, 16);
    for (int k = 0; k < N + 1; k++) step(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p_s.md
P_S -- requirements
Module: p_s

Interface
REQ-001 Parameter WORD_W, default 34, SHALL set the serial output word width in bits.
REQ-002 Parameter NUM_WORDS, default 4, SHALL set the number of words per parallel frame; frame width = WORD_W*NUM_WORDS (136).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-005 data_in_3  input  136  SHALL carry the parallel frame; sampled only on a load edge.
REQ-006 p_s_flag_in  input  1  SHALL be the load request; sampled on the rising clk edge.
REQ-007 data_out_3  output  34  SHALL carry the current serial word; registered.
REQ-008 p_s_flag_out  output  1  SHALL be high exactly when data_out_3 holds a valid word; registered.
REQ-009 busy  output  1  SHALL be high while a frame is being emitted and a new load would be refused.

Function
REQ-010 States SHALL be IDLE and SHIFT, with a 2-bit word counter cnt (0..NUM_WORDS-1) and a 136-bit frame register.
REQ-011 A load edge SHALL be a rising clk edge with p_s_flag_in=1 while in IDLE, or while in SHIFT with cnt=NUM_WORDS-1.
REQ-012 On a load edge: frame register <= data_in_3; data_out_3 <= data_in_3[135:102]; p_s_flag_out <= 1; cnt <= 0; state <= SHIFT.
REQ-013 Latency SHALL be one edge: word 0 is visible directly after the load edge, with no extra pipeline stage.
REQ-014 Word order SHALL be MSB first: word k = frame[135-34k -: 34], i.e. [135:102], [101:68], [67:34], [33:0].
REQ-015 In SHIFT with cnt<NUM_WORDS-1, each edge SHALL do cnt <= cnt+1 and data_out_3 <= word cnt+1, with p_s_flag_out held at 1.
REQ-016 p_s_flag_in SHALL be ignored while cnt<NUM_WORDS-1 in SHIFT; data_in_3 changes SHALL NOT affect the captured frame.
REQ-017 In SHIFT with cnt=NUM_WORDS-1 and no load request, the next edge SHALL return to IDLE, drive data_out_3 <= 0 and p_s_flag_out <= 0.
REQ-018 In SHIFT with cnt=NUM_WORDS-1 and p_s_flag_in=1, a back-to-back load SHALL occur per REQ-012, giving a gapless word stream.
REQ-019 busy SHALL be 1 in SHIFT when cnt<NUM_WORDS-1, and 0 otherwise.
REQ-020 In IDLE with no load request, outputs SHALL hold at data_out_3=0 and p_s_flag_out=0.
REQ-021 A full frame SHALL occupy exactly NUM_WORDS consecutive cycles of p_s_flag_out=1.

Reset
REQ-022 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, cnt=0, frame register=0, data_out_3=0, p_s_flag_out=0 and busy=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; after release no residual words SHALL be emitted until a new load edge.
REQ-024 The first edge after rst_n rises SHALL be treated as a normal edge; a load on that edge SHALL be honoured.

Verification
REQ-025 Reset check: drive rst_n=0 between edges -> data_out_3=0, p_s_flag_out=0 and busy=0 without any clk edge.
REQ-026 Single frame: data_in_3={34'h1, 34'h2, 34'h3, 34'h4} (MSB first), p_s_flag_in=1 for one edge -> data_out_3=1,2,3,4 on four consecutive cycles, flag high for those cycles, then 0/0.
REQ-027 Ignored load: pulse p_s_flag_in with a new frame while cnt=1 -> the original sequence completes unchanged and busy=1 during the pulse.
REQ-028 Back-to-back: hold p_s_flag_in=1 with frames A then B -> eight consecutive valid words A0..A3,B0..B3 with no gap.
REQ-029 Mid-frame reset: assert rst_n=0 after word 1 of frame {34'h3FFFFFFFF x4} -> outputs 0 at once; after release, idle with zeros until the next load.
REQ-030 Random stimulus: 16 random 136-bit frames with a random p_s_flag_in -> a scoreboard model built from REQ-011..REQ-021 matches data_out_3 and p_s_flag_out every cycle.
